// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: direct-mapped BHT of saturating counters plus a tagged BTB.
// Latency: IF lookup and MEM resolve are combinational; training becomes visible to lookups one cycle later.
// Backpressure: none; a MEM bubble (i_valid_mem=0) suppresses flush and training.
// Optional feature macro: BP_PERF_CNT_EN adds o_br_cnt / o_mispred_cnt event counters.
module branch_predictor_bht #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_if,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_valid_mem,
  input  logic [31:0] i_inst_mem,
  input  logic [31:0] i_pc_mem,
  input  logic        i_br_less_mem,
  input  logic        i_br_equal_mem,
  input  logic [31:0] i_target_mem,
  input  logic        i_pred_taken_mem,
  input  logic [31:0] i_pred_target_mem,
  output logic        o_flush,
  output logic        o_pc_sel,
`ifdef BP_PERF_CNT_EN
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt,
`endif
  output logic [31:0] o_redirect_pc
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Table state
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [31:0]      tgt_d [DEPTH];

  // IF-side lookup fields
  logic [IDX_W-1:0] idx_if;
  logic [TAG_W-1:0] tag_if;
  logic             hit_if;

  // MEM-side resolve fields
  logic [IDX_W-1:0] idx_mem;
  logic [TAG_W-1:0] tag_mem;
  logic             hit_mem;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_br;
  logic             is_jmp;
  logic             actual_taken;
  logic             mispredict;

  // Bits of the PC above the tag and the low alignment bits play no part in lookup.
  logic unused_bits;
  assign unused_bits = ^{i_pc_if[31:IDX_W+TAG_W+2], i_pc_if[1:0],
                         i_inst_mem[31:15], i_inst_mem[11:7]};

  assign idx_if  = i_pc_if[IDX_W+1:2];
  assign tag_if  = i_pc_if[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_mem = i_pc_mem[IDX_W+1:2];
  assign tag_mem = i_pc_mem[IDX_W+TAG_W+1:IDX_W+2];
  assign opcode  = i_inst_mem[6:0];
  assign funct3  = i_inst_mem[14:12];
  assign is_br   = (opcode == OP_BRANCH);
  assign is_jmp  = (opcode == OP_JAL) || (opcode == OP_JALR);

  // Lookup reads the registered tables, so a same-cycle update is not seen (read-before-write).
  always_comb begin
    hit_if        = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    o_pred_taken  = !i_reset && hit_if && cnt_q[idx_if][CNT_W-1];
    o_pred_target = o_pred_taken ? tgt_q[idx_if] : 32'd0;
  end

  // Resolve the real outcome in MEM and decide whether the front end must be redirected.
  always_comb begin
    actual_taken = 1'b0;
    if (is_br) begin
      case (funct3)
        3'b000:          actual_taken = i_br_equal_mem;
        3'b001:          actual_taken = !i_br_equal_mem;
        3'b100, 3'b110:  actual_taken = i_br_less_mem;
        3'b101, 3'b111:  actual_taken = !i_br_less_mem;
        default:         actual_taken = 1'b0;
      endcase
    end else if (is_jmp) begin
      actual_taken = 1'b1;
    end

    mispredict = !i_reset && i_valid_mem &&
                 ((actual_taken != i_pred_taken_mem) ||
                  (actual_taken && i_pred_taken_mem && (i_target_mem != i_pred_target_mem)));

    o_flush       = mispredict;
    o_pc_sel      = mispredict;
    o_redirect_pc = 32'd0;
    if (mispredict) begin
      o_redirect_pc = actual_taken ? i_target_mem : (i_pc_mem + 32'd4);
    end
  end

  // Compute next table contents from the MEM-stage outcome.
  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    hit_mem = valid_q[idx_mem] && (tag_q[idx_mem] == tag_mem);
    if (i_valid_mem) begin
      if (is_br) begin
        if (hit_mem) begin
          if (actual_taken) begin
            if (cnt_q[idx_mem] != CNT_MAX) cnt_d[idx_mem] = cnt_q[idx_mem] + 1'b1;
            tag_d[idx_mem] = tag_mem;
            tgt_d[idx_mem] = i_target_mem;
          end else begin
            if (cnt_q[idx_mem] != '0) cnt_d[idx_mem] = cnt_q[idx_mem] - 1'b1;
          end
        end else if (actual_taken) begin
          valid_d[idx_mem] = 1'b1;
          tag_d[idx_mem]   = tag_mem;
          tgt_d[idx_mem]   = i_target_mem;
          cnt_d[idx_mem]   = CNT_WT;
        end
      end else if (is_jmp) begin
        valid_d[idx_mem] = 1'b1;
        tag_d[idx_mem]   = tag_mem;
        tgt_d[idx_mem]   = i_target_mem;
        cnt_d[idx_mem]   = CNT_MAX;
      end else if (i_pred_taken_mem) begin
        // A non-control instruction was predicted taken: the entry is stale, drop it.
        valid_d[idx_mem] = 1'b0;
      end
    end
  end

  // Table registers; reset returns every entry to invalid and weakly not-taken.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= CNT_WNT;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Count resolved control instructions and mispredict cycles; both wrap naturally.
  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (i_valid_mem && (is_br || is_jmp)) br_cnt_d = br_cnt_q + 32'd1;
    if (mispredict) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // Event counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule
